// File: rtl/multiplier_pkg.sv
// ============================================================================
// Module      : multiplier_pkg
// Description : Shared state encoding and width helpers for multiplier_seq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package multiplier_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int c_MIN_WIDTH = 2;

    // Product/accumulator width for a given operand width.
    function automatic int prod_width(input int w);
        return 2 * w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mult_sign_adjust.sv
// ============================================================================
// Module      : mult_sign_adjust
// Description : Operand magnitude, result sign, and conditional 2*WIDTH negate
//               for two's-complement multiplication.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_sign_adjust
    import multiplier_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                         i_sgn,
    input  logic [WIDTH-1:0]             i_in1,
    input  logic [WIDTH-1:0]             i_in2,
    input  logic                         i_neg_q,
    input  logic [prod_width(WIDTH)-1:0] i_pr,
    output logic [WIDTH-1:0]             o_mag1,
    output logic [WIDTH-1:0]             o_mag2,
    output logic                         o_neg,
    output logic [prod_width(WIDTH)-1:0] o_res
);

    // The most negative value maps onto itself, which is the correct
    // unsigned magnitude 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] magnitude(input logic sgn,
                                                   input logic [WIDTH-1:0] v);
        return (sgn && v[WIDTH-1]) ? (~v + 1'b1) : v;
    endfunction

    assign o_mag1 = magnitude(i_sgn, i_in1);
    assign o_mag2 = magnitude(i_sgn, i_in2);
    assign o_neg  = i_sgn & (i_in1[WIDTH-1] ^ i_in2[WIDTH-1]);
    assign o_res  = i_neg_q ? (~i_pr + 1'b1) : i_pr;

endmodule

`default_nettype wire

// File: rtl/multiplier_seq.sv
// ============================================================================
// Module      : multiplier_seq
// Description : Radix-2 shift-and-add multiplier with start/done handshake and
//               early termination. Define MULT_SIGNED_EN for signed support.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multiplier_seq
    import multiplier_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         S,
    input  logic                         SGN,
    input  logic [WIDTH-1:0]             IN1,
    input  logic [WIDTH-1:0]             IN2,
    output logic                         BUSY,
    output logic                         F,
    output logic [prod_width(WIDTH)-1:0] M
);

    localparam int c_PW = prod_width(WIDTH);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  ar_q, ar_d;
    logic [c_PW-1:0]   br_q, br_d;
    logic [c_PW-1:0]   pr_q, pr_d;
    logic [c_PW-1:0]   m_q, m_d;
    logic              neg_q, neg_d;

    logic [WIDTH-1:0]  w_mag1;
    logic [WIDTH-1:0]  w_mag2;
    logic              w_neg;
    logic [c_PW-1:0]   w_res;

`ifdef MULT_SIGNED_EN
    mult_sign_adjust #(
        .WIDTH (WIDTH)
    ) u_sign_adjust (
        .i_sgn   (SGN),
        .i_in1   (IN1),
        .i_in2   (IN2),
        .i_neg_q (neg_q),
        .i_pr    (pr_q),
        .o_mag1  (w_mag1),
        .o_mag2  (w_mag2),
        .o_neg   (w_neg),
        .o_res   (w_res)
    );
`else
    logic w_unused_sgn;

    assign w_unused_sgn = SGN ^ neg_q;
    assign w_mag1       = IN1;
    assign w_mag2       = IN2;
    assign w_neg        = 1'b0;
    assign w_res        = pr_q;
`endif

    always_comb begin
        state_d = state_q;
        ar_d    = ar_q;
        br_d    = br_q;
        pr_d    = pr_q;
        m_d     = m_q;
        neg_d   = neg_q;
        case (state_q)
            IDLE: begin
                if (S) begin
                    ar_d    = w_mag1;
                    br_d    = {{(c_PW-WIDTH){1'b0}}, w_mag2};
                    pr_d    = '0;
                    neg_d   = w_neg;
                    state_d = CALC;
                end
            end
            CALC: begin
                // Terminate as soon as no set multiplier bits remain.
                if (ar_q != '0) begin
                    if (ar_q[0]) begin
                        pr_d = pr_q + br_q;
                    end
                    ar_d = ar_q >> 1;
                    br_d = br_q << 1;
                end else begin
                    m_d     = w_res;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            ar_q    <= '0;
            br_q    <= '0;
            pr_q    <= '0;
            m_q     <= '0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ar_q    <= ar_d;
            br_q    <= br_d;
            pr_q    <= pr_d;
            m_q     <= m_d;
            neg_q   <= neg_d;
        end
    end

    assign BUSY = (state_q != IDLE);
    assign F    = (state_q == DONE);
    assign M    = m_q;

endmodule

`default_nettype wire
